// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage definitions: PC-control encodings, fetch FSM states, IF/ID payload.
package fetch_stage_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned CTRL_W = 2;

    localparam logic [CTRL_W-1:0] PC_NEXT = 2'b00;
    localparam logic [CTRL_W-1:0] PC_HOLD = 2'b01;
    localparam logic [CTRL_W-1:0] PC_JUMP = 2'b10;
    localparam logic [CTRL_W-1:0] PC_JALR = 2'b11;

    // addi x0,x0,0
    localparam logic [XLEN-1:0] NOP_INSR_ENC = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_REQ   = 2'b01,
        ST_WAIT  = 2'b10,
        ST_FLUSH = 2'b11
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] insr;
        logic            bubble;
    } ifid_t;

    // JALR targets are halfword-aligned by clearing bit 0
    function automatic logic [XLEN-1:0] jalr_align(input logic [XLEN-1:0] target);
        return target & ~XLEN'(1);
    endfunction

endpackage

// File: rtl/fetch_stage_buffer.sv
// One-entry fetched-instruction buffer with same-cycle response bypass.
module fetch_buffer
    import fetch_stage_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            write,
    input  logic            consume,
    input  logic            clear,
    input  logic            bypass_valid,
    input  logic [XLEN-1:0] rsp_data,
    output logic            buf_valid,
    output logic            avail_c,
    output logic [XLEN-1:0] data_c
);

    logic [XLEN-1:0] buf_data;

    // Capture a response that nobody consumed this cycle; consume/clear empty the entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_valid <= 1'b0;
            buf_data  <= '0;
        end else begin
            if (clear || consume) begin
                buf_valid <= 1'b0;
            end else if (write) begin
                buf_valid <= 1'b1;
            end
            if (write) begin
                buf_data <= rsp_data;
            end
        end
    end

    // Buffered data takes priority; otherwise forward the live response
    always_comb begin
        avail_c = buf_valid || bypass_valid;
        data_c  = buf_valid ? buf_data : rsp_data;
    end

endmodule

// File: rtl/fetch_stage.sv
// PC register, single-outstanding imem fetch engine and IF/ID pipeline register.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INSR = NOP_INSR_ENC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CTRL_W-1:0] next_pc_control,
    input  logic              next_nop,
    input  logic [XLEN-1:0]   jump_target,
    input  logic [XLEN-1:0]   jalr_target,
    output logic              imem_req_valid,
    output logic [XLEN-1:0]   imem_req_addr,
    input  logic              imem_req_ready,
    input  logic              imem_rsp_valid,
    input  logic [XLEN-1:0]   imem_rsp_data,
    output logic [XLEN-1:0]   id_pc,
    output logic [XLEN-1:0]   id_insr,
    output logic              id_bubble
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    ifid_t           ifid_q, ifid_d;
    logic            req_valid_q;

    logic            redirect_c;
    logic            accept_c;
    logic            rsp_in_wait_c;
    logic            take_c;
    logic            buf_write_c;
    logic            buf_valid;
    logic            avail_c;
    logic [XLEN-1:0] instr_c;

    // Decode per-cycle handshake and control events
    always_comb begin
        redirect_c    = next_pc_control[1];
        accept_c      = (state_q == ST_REQ) && imem_req_ready;
        rsp_in_wait_c = (state_q == ST_WAIT) && imem_rsp_valid;
        take_c        = (next_pc_control == PC_NEXT) && avail_c;
        buf_write_c   = rsp_in_wait_c && !take_c && !redirect_c;
    end

    fetch_buffer u_buf (
        .clk          (clk),
        .rst          (rst),
        .write        (buf_write_c),
        .consume      (take_c),
        .clear        (redirect_c),
        .bypass_valid (rsp_in_wait_c),
        .rsp_data     (imem_rsp_data),
        .buf_valid    (buf_valid),
        .avail_c      (avail_c),
        .data_c       (instr_c)
    );

    // Fetch FSM state register; request-valid is registered from the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            req_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_valid_q <= (state_d == ST_REQ);
        end
    end

    // Fetch FSM next state, including redirect handling of in-flight requests
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (redirect_c || !buf_valid) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (accept_c) begin
                    state_d = redirect_c ? ST_FLUSH : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_rsp_valid) begin
                    state_d = redirect_c ? ST_REQ : ST_IDLE;
                end else if (redirect_c) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (imem_rsp_valid) begin
                    state_d = ST_REQ;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Next PC and IF/ID contents; redirect overrides any available instruction
    always_comb begin
        pc_d   = pc_q;
        ifid_d = ifid_q;
        unique case (next_pc_control)
            PC_NEXT: begin
                ifid_d = '{pc: pc_q, insr: NOP_INSR, bubble: 1'b1};
                if (avail_c) begin
                    pc_d = pc_q + XLEN'(4);
                    if (!next_nop) begin
                        ifid_d = '{pc: pc_q, insr: instr_c, bubble: 1'b0};
                    end
                end
            end
            PC_HOLD: begin
                if (next_nop) begin
                    ifid_d = '{pc: pc_q, insr: NOP_INSR, bubble: 1'b1};
                end
            end
            PC_JUMP: begin
                pc_d   = jump_target;
                ifid_d = '{pc: pc_q, insr: NOP_INSR, bubble: 1'b1};
            end
            PC_JALR: begin
                pc_d   = jalr_align(jalr_target);
                ifid_d = '{pc: pc_q, insr: NOP_INSR, bubble: 1'b1};
            end
            default: begin
                pc_d   = pc_q;
                ifid_d = ifid_q;
            end
        endcase
    end

    // PC and IF/ID pipeline registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q   <= RESET_PC;
            ifid_q <= '{pc: '0, insr: NOP_INSR, bubble: 1'b1};
        end else begin
            pc_q   <= pc_d;
            ifid_q <= ifid_d;
        end
    end

    assign imem_req_valid = req_valid_q;
    assign imem_req_addr  = pc_q;
    assign id_pc          = ifid_q.pc;
    assign id_insr        = ifid_q.insr;
    assign id_bubble      = ifid_q.bubble;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed + randomized bench for fetch_stage against a flag-level reference model.
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic [1:0]  next_pc_control;
    logic        next_nop;
    logic [31:0] jump_target;
    logic [31:0] jalr_target;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [31:0] id_pc;
    logic [31:0] id_insr;
    logic        id_bubble;

    fetch_stage #(.RESET_PC(RST_PC), .NOP_INSR(NOP)) dut (
        .clk             (clk),
        .rst             (rst),
        .next_pc_control (next_pc_control),
        .next_nop        (next_nop),
        .jump_target     (jump_target),
        .jalr_target     (jalr_target),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_rsp_valid  (imem_rsp_valid),
        .imem_rsp_data   (imem_rsp_data),
        .id_pc           (id_pc),
        .id_insr         (id_insr),
        .id_bubble       (id_bubble)
    );

    always #5 clk = ~clk;

    int n_checks;
    int n_errors;

    // Reference model: fetch engine as requesting / outstanding / stale flags
    logic [31:0] m_pc;
    logic        m_req;
    logic        m_out;
    logic        m_stale;
    logic        m_buf_v;
    logic [31:0] m_buf_d;
    logic [31:0] m_id_pc;
    logic [31:0] m_id_insr;
    logic        m_id_bub;

    // Instruction memory: one pending response with a countdown
    logic        mem_pending;
    logic [31:0] mem_addr;
    int unsigned mem_delay;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc        = RST_PC;
        m_req       = 1'b0;
        m_out       = 1'b0;
        m_stale     = 1'b0;
        m_buf_v     = 1'b0;
        m_buf_d     = '0;
        m_id_pc     = '0;
        m_id_insr   = NOP;
        m_id_bub    = 1'b1;
        mem_pending = 1'b0;
        mem_addr    = '0;
        mem_delay   = 0;
    endtask

    task automatic check_reset_values();
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_req_addr",  imem_req_addr, RST_PC);
        chk("rst_id_pc",     id_pc, 32'd0);
        chk("rst_id_insr",   id_insr, NOP);
        chk("rst_id_bubble", 32'(id_bubble), 32'd1);
    endtask

    task automatic check_all();
        chk("req_valid", 32'(imem_req_valid), 32'(m_req));
        chk("req_addr",  imem_req_addr, m_pc);
        chk("id_pc",     id_pc, m_id_pc);
        chk("id_insr",   id_insr, m_id_insr);
        chk("id_bubble", 32'(id_bubble), 32'(m_id_bub));
    endtask

    // One clock: drive inputs, advance model and memory, check after the edge
    task automatic step(input logic [1:0] c, input logic n, input logic [31:0] jt,
                        input logic [31:0] jrt, input logic rdy, input int unsigned lat,
                        input logic stray);
        logic        redirect;
        logic        got_rsp;
        logic        avail;
        logic        accepted;
        logic        n_req;
        logic        n_out;
        logic        n_stale;
        logic [31:0] instr;
        logic [31:0] pc_old;

        next_pc_control = c;
        next_nop        = n;
        jump_target     = jt;
        jalr_target     = jrt;
        imem_req_ready  = rdy;
        if (mem_pending && mem_delay == 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_fn(mem_addr);
        end else if (stray) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = 32'hDEAD_BEEF;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom();
        end

        pc_old   = m_pc;
        redirect = c[1];
        got_rsp  = m_out && imem_rsp_valid;
        avail    = m_buf_v || (got_rsp && !m_stale);
        instr    = m_buf_v ? m_buf_d : imem_rsp_data;
        accepted = m_req && rdy;

        n_req   = m_req;
        n_out   = m_out;
        n_stale = m_stale;
        if (m_req) begin
            if (accepted) begin
                n_req   = 1'b0;
                n_out   = 1'b1;
                n_stale = redirect;
            end
        end else if (m_out) begin
            if (got_rsp) begin
                n_out   = 1'b0;
                n_stale = 1'b0;
                n_req   = redirect || m_stale;
            end else if (redirect) begin
                n_stale = 1'b1;
            end
        end else begin
            n_req = redirect || !m_buf_v;
        end

        if (redirect) begin
            m_id_pc = pc_old; m_id_insr = NOP; m_id_bub = 1'b1;
        end else if (c == 2'b00) begin
            m_id_pc = pc_old;
            if (avail && !n) begin
                m_id_insr = instr; m_id_bub = 1'b0;
            end else begin
                m_id_insr = NOP; m_id_bub = 1'b1;
            end
        end else if (n) begin
            m_id_pc = pc_old; m_id_insr = NOP; m_id_bub = 1'b1;
        end

        if (redirect || (c == 2'b00 && avail)) begin
            m_buf_v = 1'b0;
        end else if (got_rsp && !m_stale) begin
            m_buf_v = 1'b1;
            m_buf_d = imem_rsp_data;
        end

        if (c == 2'b10)                m_pc = jt;
        else if (c == 2'b11)           m_pc = {jrt[31:1], 1'b0};
        else if (c == 2'b00 && avail)  m_pc = pc_old + 32'd4;

        if (mem_pending && mem_delay == 0) mem_pending = 1'b0;
        else if (mem_pending)              mem_delay = mem_delay - 1;
        if (accepted) begin
            mem_pending = 1'b1;
            mem_addr    = pc_old;
            mem_delay   = lat;
        end

        m_req   = n_req;
        m_out   = n_out;
        m_stale = n_stale;

        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        logic [31:0] hold_pc;
        logic [31:0] bp_addr;
        logic        hit;

        n_checks = 0;
        n_errors = 0;
        clk = 1'b0;
        rst = 1'b1;
        next_pc_control = 2'b00;
        next_nop = 1'b0;
        jump_target = '0;
        jalr_target = '0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data = '0;
        model_reset();

        #2;
        check_reset_values();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Sequential fetch from RESET_PC with a 1-cycle memory
        repeat (12) step(2'b00, 1'b0, '0, '0, 1'b1, 0, 1'b0);

        // Hold with a buffered instruction, then release
        for (int i = 0; i < 20 && !m_buf_v; i++) step(2'b01, 1'b0, '0, '0, 1'b1, 0, 1'b0);
        chk("hold_buf_filled", 32'(m_buf_v), 32'd1);
        hold_pc = m_pc;
        repeat (3) begin
            step(2'b01, 1'b0, '0, '0, 1'b1, 0, 1'b0);
            chk("hold_pc", imem_req_addr, hold_pc);
            chk("hold_no_req", 32'(imem_req_valid), 32'd0);
        end
        step(2'b00, 1'b0, '0, '0, 1'b1, 0, 1'b0);
        chk("release_id_pc", id_pc, hold_pc);
        chk("release_not_bubble", 32'(id_bubble), 32'd0);

        // Jump while waiting on a slow response
        for (int i = 0; i < 20 && !(m_out && !m_stale); i++) step(2'b00, 1'b0, '0, '0, 1'b1, 2, 1'b0);
        step(2'b10, 1'b0, 32'h0000_0200, '0, 1'b1, 2, 1'b0);
        chk("jump_addr", imem_req_addr, 32'h0000_0200);
        chk("jump_flush_no_req", 32'(imem_req_valid), 32'd0);
        chk("jump_bubble", 32'(id_bubble), 32'd1);
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            step(2'b00, 1'b0, '0, '0, 1'b1, 0, 1'b0);
            hit = (id_pc == 32'h0000_0200) && !id_bubble;
        end
        chk("jump_delivered", 32'(hit), 32'd1);

        // JALR in the same cycle as a response
        for (int i = 0; i < 20 && !(m_out && !m_stale && mem_pending && mem_delay == 0); i++)
            step(2'b00, 1'b0, '0, '0, 1'b1, 0, 1'b0);
        step(2'b11, 1'b0, '0, 32'h0000_0301, 1'b1, 0, 1'b0);
        chk("jalr_addr", imem_req_addr, 32'h0000_0300);
        chk("jalr_req", 32'(imem_req_valid), 32'd1);
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            step(2'b00, 1'b0, '0, '0, 1'b1, 0, 1'b0);
            hit = (id_pc == 32'h0000_0300) && !id_bubble;
        end
        chk("jalr_delivered", 32'(hit), 32'd1);

        // Backpressure: request held with a stable address
        for (int i = 0; i < 20 && !m_req; i++) step(2'b00, 1'b0, '0, '0, 1'b1, 0, 1'b0);
        bp_addr = m_pc;
        repeat (5) begin
            step(2'b00, 1'b0, '0, '0, 1'b0, 0, 1'b0);
            chk("bp_req_valid", 32'(imem_req_valid), 32'd1);
            chk("bp_addr", imem_req_addr, bp_addr);
            chk("bp_bubble", 32'(id_bubble), 32'd1);
        end

        // PC wraps past 0xFFFF_FFFC
        step(2'b10, 1'b0, 32'hFFFF_FFFC, '0, 1'b1, 0, 1'b0);
        for (int i = 0; i < 20 && !m_buf_v; i++) step(2'b01, 1'b0, '0, '0, 1'b1, 0, 1'b0);
        step(2'b00, 1'b0, '0, '0, 1'b1, 0, 1'b0);
        chk("wrap_pc", imem_req_addr, 32'h0000_0000);
        chk("wrap_id_pc", id_pc, 32'hFFFF_FFFC);

        // Randomized control, targets, backpressure and latency
        for (int i = 0; i < 400; i++) begin
            int unsigned r;
            logic [1:0]  c;
            r = $urandom_range(0, 99);
            c = (r < 60) ? 2'b00 : (r < 80) ? 2'b01 : (r < 90) ? 2'b10 : 2'b11;
            step(c, ($urandom_range(0, 9) == 0),
                 32'h0000_1000 + (32'($urandom_range(0, 63)) << 2),
                 32'h0000_2000 + 32'($urandom_range(0, 255)),
                 ($urandom_range(0, 9) < 7), $urandom_range(0, 3), 1'b0);
        end

        // Async reset mid-WAIT, then a stray late response
        for (int i = 0; i < 20 && !(m_out && !m_stale); i++) step(2'b00, 1'b0, '0, '0, 1'b1, 3, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_reset_values();
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        step(2'b00, 1'b0, '0, '0, 1'b1, 0, 1'b1);
        chk("post_rst_req_valid", 32'(imem_req_valid), 32'd1);
        chk("post_rst_req_addr", imem_req_addr, RST_PC);
        repeat (10) step(2'b00, 1'b0, '0, '0, 1'b1, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- PC register, single-outstanding instruction-memory fetch engine, and IF/ID pipeline register.
- Sits directly upstream of the ID-stage hazard/stall logic and consumes its next_pc_control/next_nop decision every cycle.
- Delivers id_pc/id_insr to ID, injects NOP bubbles, and discards stale fetches on redirect.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSR, 32'h0000_0013, encoding used for bubbles (addi x0,x0,0).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- next_pc_control  in  2  00: PC+4, 01: hold, 10: jump, 11: jalr.
- next_nop  in  1  load NOP into IF/ID this cycle.
- jump_target  in  32  branch/JAL target, used when control=10.
- jalr_target  in  32  JALR target, used when control=11; bit 0 forced to 0.
- imem_req_valid  out  1  fetch request valid.
- imem_req_addr  out  32  fetch address; always equals pc.
- imem_req_ready  in  1  request accepted when valid&&ready.
- imem_rsp_valid  in  1  response data valid; in order, ≥1 cycle after acceptance.
- imem_rsp_data  in  32  fetched instruction.
- id_pc  out  32  PC of the instruction in IF/ID.
- id_insr  out  32  instruction in IF/ID.
- id_bubble  out  1  IF/ID holds an injected NOP.

Behaviour:
- Reset values:
  - pc=RESET_PC, state=IDLE, buf_valid=0.
  - id_pc=0, id_insr=NOP_INSR, id_bubble=1, imem_req_valid=0.
- FSM states: IDLE, REQ, WAIT, FLUSH.
  - imem_req_valid = (state==REQ).
- IDLE: if buf_valid=0, go to REQ next cycle; otherwise stay.
- REQ: on valid&&ready go to WAIT; otherwise stay, with addr tracking pc.
- WAIT: on rsp_valid, go to IDLE.
  - Data goes to buf unless consumed the same cycle (see avail).
- FLUSH: the in-flight response is stale.
  - On rsp_valid, drop the data and go to REQ.
- avail = buf_valid || (state==WAIT && imem_rsp_valid).
  - Instruction source: buf data if buf_valid, else imem_rsp_data (same-cycle bypass).
- Per-cycle action by next_pc_control:
  - 00 with avail:
    - IF/ID <= {pc, instr}, or NOP if next_nop.
    - pc <= pc+4 (mod 2^32, wraps silently).
    - Buffer consumed (buf_valid <= 0).
  - 00 without avail:
    - IF/ID <= bubble {pc, NOP_INSR, id_bubble=1}.
    - pc holds; fetch continues.
  - 01:
    - pc, buf, and fetch progress unchanged.
    - IF/ID holds, or becomes a bubble if next_nop.
  - 10/11:
    - pc <= target; IF/ID <= bubble regardless of next_nop; buf_valid <= 0.
    - Fetch state on redirect:
      - REQ not accepted this cycle: stay REQ with the new addr.
      - REQ accepted this cycle: FLUSH.
      - WAIT without rsp: FLUSH.
      - WAIT with rsp this cycle: drop the response, REQ.
      - IDLE: REQ.
      - FLUSH: stay FLUSH.
- Redirect wins over a simultaneous avail: the fetched data is never delivered.
- At most one request outstanding.
  - No new request issues while buf_valid=1 or the state is WAIT/FLUSH.
- imem_rsp_valid outside WAIT/FLUSH is a protocol error and is ignored.
- Async reset mid-fetch returns to IDLE. A late response arriving after reset is ignored, since the state is no longer WAIT.
- Latency: with a 1-cycle memory, steady state is one instruction per 3 cycles (REQ, WAIT, consume via bypass).
- Bubbles carry id_pc = the current pc value, so ID-side PC-relative logic stays defined.

Decomposition:
- Shared package/header (alongside the existing opcode definitions) holds:
  - PC-control encodings PC_NEXT=2'b00, PC_HOLD=2'b01, PC_JUMP=2'b10, PC_JALR=2'b11.
  - Fetch FSM state encodings.
  - NOP_INSR constant.
- One natural sub-module, fetch_buffer: 1-entry data register, valid flag, and bypass mux.
  - Interface: write, consume, clear, avail, data.

Test Plan:
- Reset with RESET_PC=0x100, memory ready/1-cycle latency, control=00 → requests at 0x100, 0x104, 0x108. IF/ID shows id_pc 0x100, then 0x104, each preceded by bubbles. id_insr matches memory.
- Hold: control=01 for 3 cycles with buf_valid=1 → pc, id_pc, and id_insr unchanged, no new request. Release → buffered instruction enters IF/ID next cycle.
- Jump while in WAIT: control=10, jump_target=0x200, rsp arrives 2 cycles later → FSM enters FLUSH, stale data dropped. Next request addr=0x200; IF/ID is a bubble until 0x200 is delivered.
- Redirect in the same cycle as rsp_valid: control=11, jalr_target=0x301 → response dropped. Next request addr=0x300 (bit 0 cleared). No stale id_insr ever appears.
- Memory backpressure: imem_req_ready=0 for 5 cycles → imem_req_valid stays 1 with constant addr. IF/ID shows bubbles (id_bubble=1), and pc is unchanged.
- Async reset asserted mid-WAIT, then rsp_valid pulses → outputs immediately at reset values. The response is ignored and the first post-reset request goes to RESET_PC. Also check pc=0xFFFF_FFFC with control=00 → next pc=0x0000_0000.
